// File: rtl/fb_write_arb.sv
// Round-robin arbiter sharing one framebuffer write port among NREQ drawing engines.
// Define FB_WRITE_ARB_CLEAR_EN to add a full-framebuffer clear sequencer.
module fb_write_arb #(
    parameter int NREQ      = 2,
    parameter int ADDRW     = 16,
    parameter int CIDXW     = 4,
    parameter int MAX_BURST = 64,
    parameter int FB_PIXELS = 57600
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*ADDRW-1:0]  req_addr,
    input  logic [NREQ*CIDXW-1:0]  req_cidx,
`ifdef FB_WRITE_ARB_CLEAR_EN
    input  logic                   clear_start,
    input  logic [CIDXW-1:0]       clear_cidx,
    output logic                   clear_done,
`endif
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        grant,
    output logic                   fb_we,
    output logic [ADDRW-1:0]       fb_addr,
    output logic [CIDXW-1:0]       fb_cidx,
    output logic                   busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
`ifdef FB_WRITE_ARB_CLEAR_EN
        , CLEAR = 2'd2
`endif
    } state_t;

    state_t            state_r, state_s;
    logic [NREQ-1:0]   grant_r, grant_s;
    logic [IDXW-1:0]   ptr_r, ptr_s;
    logic [CNTW-1:0]   cnt_r, cnt_s;
    logic              fb_we_r, fb_we_s;
    logic [ADDRW-1:0]  fb_addr_r, fb_addr_s;
    logic [CIDXW-1:0]  fb_cidx_r, fb_cidx_s;

    logic              pick_found_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic [IDXW-1:0]   cand_s;
    logic [IDXW-1:0]   owner_s;
    logic              acc_s;
    logic              last_s;
    logic [ADDRW-1:0]  sel_addr_s;
    logic [CIDXW-1:0]  sel_cidx_s;
    logic              clear_go_s;

`ifdef FB_WRITE_ARB_CLEAR_EN
    logic [ADDRW-1:0]  clr_addr_r, clr_addr_s;
    logic [CIDXW-1:0]  clr_cidx_r, clr_cidx_s;
    logic              clear_done_r, clear_done_s;

    assign clear_go_s = clear_start;
    assign clear_done = clear_done_r;
`else
    logic              unused_fb_pixels;

    assign clear_go_s       = 1'b0;
    assign unused_fb_pixels = ^FB_PIXELS;
`endif

    assign req_ready = grant_r & req_valid;
    assign grant     = grant_r;
    assign fb_we     = fb_we_r;
    assign fb_addr   = fb_addr_r;
    assign fb_cidx   = fb_cidx_r;
    assign busy      = (state_r != IDLE);

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = ptr_r;
        cand_s       = ptr_r;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDXW'((int'(ptr_r) + k) % NREQ);
            if (!pick_found_s && req_valid[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Decode the current owner and select its beat.
    always_comb begin
        owner_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_s = grant_r[i] ? IDXW'(i) : owner_s;
        end
        acc_s      = |(grant_r & req_valid);
        last_s     = req_last[owner_s];
        sel_addr_s = req_addr[owner_s*ADDRW +: ADDRW];
        sel_cidx_s = req_cidx[owner_s*CIDXW +: CIDXW];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        fb_we_s   = 1'b0;
        fb_addr_s = fb_addr_r;
        fb_cidx_s = fb_cidx_r;
`ifdef FB_WRITE_ARB_CLEAR_EN
        clr_addr_s   = clr_addr_r;
        clr_cidx_s   = clr_cidx_r;
        clear_done_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (clear_go_s) begin
`ifdef FB_WRITE_ARB_CLEAR_EN
                    state_s    = CLEAR;
                    clr_addr_s = '0;
                    clr_cidx_s = clear_cidx;
`endif
                end else if (pick_found_s) begin
                    state_s = GRANT;
                    grant_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (acc_s) begin
                    fb_we_s   = 1'b1;
                    fb_addr_s = sel_addr_s;
                    fb_cidx_s = sel_cidx_s;
                    cnt_s     = cnt_r + CNTW'(1);
                    // Release on the owner's last beat or when the burst cap is reached.
                    if (last_s || (cnt_r == CNTW'(MAX_BURST - 1))) begin
                        state_s = IDLE;
                        grant_s = '0;
                        ptr_s   = (owner_s == IDXW'(NREQ - 1)) ? '0 : owner_s + IDXW'(1);
                    end else begin
                        state_s = GRANT;
                    end
                end else begin
                    state_s = GRANT;
                end
            end
`ifdef FB_WRITE_ARB_CLEAR_EN
            CLEAR: begin
                fb_we_s   = 1'b1;
                fb_addr_s = clr_addr_r;
                fb_cidx_s = clr_cidx_r;
                if (clr_addr_r == ADDRW'(FB_PIXELS - 1)) begin
                    clear_done_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    clr_addr_s = clr_addr_r + ADDRW'(1);
                end
            end
`endif
            default: begin
                state_s = IDLE;
                grant_s = '0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            fb_we_r   <= 1'b0;
            fb_addr_r <= '0;
            fb_cidx_r <= '0;
`ifdef FB_WRITE_ARB_CLEAR_EN
            clr_addr_r   <= '0;
            clr_cidx_r   <= '0;
            clear_done_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            fb_we_r   <= fb_we_s;
            fb_addr_r <= fb_addr_s;
            fb_cidx_r <= fb_cidx_s;
`ifdef FB_WRITE_ARB_CLEAR_EN
            clr_addr_r   <= clr_addr_s;
            clr_cidx_r   <= clr_cidx_s;
            clear_done_r <= clear_done_s;
`endif
        end
    end

endmodule

// File: tb/tb_fb_write_arb.sv
// Scoreboard bench for fb_write_arb: expected writes and grant owners are queued
// by the stimulus and checked by an independent monitor.
module tb_fb_write_arb;

    localparam int NREQ  = 2;
    localparam int ADDRW = 16;
    localparam int CIDXW = 4;
    localparam int MAXB  = 4;
    localparam int NPIX  = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ*ADDRW-1:0] req_addr = '0;
    logic [NREQ*CIDXW-1:0] req_cidx = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       grant;
    logic                  fb_we;
    logic [ADDRW-1:0]      fb_addr;
    logic [CIDXW-1:0]      fb_cidx;
    logic                  busy;
`ifdef FB_WRITE_ARB_CLEAR_EN
    logic                  clear_start = 1'b0;
    logic [CIDXW-1:0]      clear_cidx = '0;
    logic                  clear_done;
`endif

    fb_write_arb #(
        .NREQ(NREQ), .ADDRW(ADDRW), .CIDXW(CIDXW), .MAX_BURST(MAXB), .FB_PIXELS(NPIX)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last),
        .req_addr(req_addr), .req_cidx(req_cidx),
`ifdef FB_WRITE_ARB_CLEAR_EN
        .clear_start(clear_start), .clear_cidx(clear_cidx), .clear_done(clear_done),
`endif
        .req_ready(req_ready), .grant(grant),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_cidx(fb_cidx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDRW-1:0] addr;
        logic [CIDXW-1:0] cidx;
        logic             done;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_own[$];
    int  total = 0;
    int  bad = 0;
    wr_t mon_e;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_wr(input logic [ADDRW-1:0] a, input logic [CIDXW-1:0] c, input logic d);
        wr_t e;
        e.addr = a;
        e.cidx = c;
        e.done = d;
        exp_wr.push_back(e);
    endtask

    task automatic send_beat(input int r, input logic [ADDRW-1:0] a, input logic [CIDXW-1:0] c,
                             input logic l);
        int t;
        t = 0;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_last[r]  = l;
        req_addr[r*ADDRW +: ADDRW] = a;
        req_cidx[r*CIDXW +: CIDXW] = c;
        #1;
        while (!req_ready[r] && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic burst(input int r, input int n, input logic [ADDRW-1:0] a0,
                         input logic [CIDXW-1:0] c0);
        for (int i = 0; i < n; i++) begin
            send_beat(r, a0 + ADDRW'(i), c0 + CIDXW'(i), (i == n - 1));
        end
    endtask

    task automatic drop(input int r);
        @(negedge clk);
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    // Monitor: compare every write and every new grant against the queues.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fb_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {16'd0, fb_addr}, 32'hffff_ffff);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_addr", {16'd0, fb_addr}, {16'd0, mon_e.addr});
                    check("wr_cidx", {28'd0, fb_cidx}, {28'd0, mon_e.cidx});
`ifdef FB_WRITE_ARB_CLEAR_EN
                    check("clear_done", {31'd0, clear_done}, {31'd0, mon_e.done});
`endif
                end
            end
            if (grant != '0 && grant != prev_grant) begin
                check("dead_cycle", {30'd0, prev_grant}, 32'd0);
                if (exp_own.size() == 0) begin
                    check("unexpected_grant", {30'd0, grant}, 32'd0);
                end else begin
                    check("grant_owner", {30'd0, grant}, 32'd1 << exp_own.pop_front());
                end
            end
            if ((req_valid & ~grant) != '0) begin
                check("nonowner_ready", {30'd0, req_ready & ~grant}, 32'd0);
            end
            prev_grant = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_ready", {30'd0, req_ready}, 32'd0);
        check("rst_we", {31'd0, fb_we}, 32'd0);
        check("rst_addr", {16'd0, fb_addr}, 32'd0);
        check("rst_cidx", {28'd0, fb_cidx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 3-beat burst from requester 0
        push_wr(16'd10, 4'd1, 1'b0);
        push_wr(16'd11, 4'd2, 1'b0);
        push_wr(16'd12, 4'd3, 1'b0);
        exp_own.push_back(0);
        fork
            begin burst(0, 3, 16'd10, 4'd1); drop(0); end
            begin
                @(negedge clk);
                @(posedge clk); #1;
                check("t1_grant", {30'd0, grant}, 32'd1);
                check("t1_busy", {31'd0, busy}, 32'd1);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("t1_we", {31'd0, fb_we}, 32'd1);
                end
                check("t1_release", {30'd0, grant}, 32'd0);
                check("t1_idle", {31'd0, busy}, 32'd0);
                @(posedge clk); #1;
                check("t1_we_off", {31'd0, fb_we}, 32'd0);
            end
        join
        repeat (3) @(negedge clk);

        // Both requesters continuously valid, bursts of 2; pointer now favours 1
        foreach (exp_own[i]) check("t2_pre_own_empty", 32'd1, 32'd0);
        exp_own.push_back(1); exp_own.push_back(0);
        exp_own.push_back(1); exp_own.push_back(0);
        push_wr(16'd200, 4'd8, 1'b0);  push_wr(16'd201, 4'd9, 1'b0);
        push_wr(16'd100, 4'd4, 1'b0);  push_wr(16'd101, 4'd5, 1'b0);
        push_wr(16'd202, 4'd10, 1'b0); push_wr(16'd203, 4'd11, 1'b0);
        push_wr(16'd102, 4'd6, 1'b0);  push_wr(16'd103, 4'd7, 1'b0);
        fork
            begin burst(0, 2, 16'd100, 4'd4); burst(0, 2, 16'd102, 4'd6); drop(0); end
            begin burst(1, 2, 16'd200, 4'd8); burst(1, 2, 16'd202, 4'd10); drop(1); end
        join
        repeat (3) @(negedge clk);

        // Burst cap: requester 1 sends 6 beats, cut after 4, requester 0 slips in
        exp_own.push_back(1); exp_own.push_back(0); exp_own.push_back(1);
        for (int i = 0; i < 4; i++) push_wr(16'd320 + 16'(i), 4'd1 + 4'(i), 1'b0);
        push_wr(16'd330, 4'd12, 1'b0); push_wr(16'd331, 4'd13, 1'b0);
        push_wr(16'd324, 4'd5, 1'b0);  push_wr(16'd325, 4'd6, 1'b0);
        fork
            begin burst(1, 6, 16'd320, 4'd1); drop(1); end
            begin burst(0, 2, 16'd330, 4'd12); drop(0); end
        join
        repeat (3) @(negedge clk);

        // Owner drops valid for 5 cycles mid-burst
        exp_own.push_back(0);
        push_wr(16'd300, 4'd1, 1'b0); push_wr(16'd301, 4'd2, 1'b0); push_wr(16'd302, 4'd3, 1'b0);
        send_beat(0, 16'd300, 4'd1, 1'b0);
        drop(0);
        repeat (5) begin
            @(posedge clk); #1;
            check("t4_hold", {30'd0, grant}, 32'd1);
            check("t4_gap_we", {31'd0, fb_we}, 32'd0);
        end
        send_beat(0, 16'd301, 4'd2, 1'b0);
        send_beat(0, 16'd302, 4'd3, 1'b1);
        drop(0);
        repeat (3) @(negedge clk);

        // Reset after the 2nd accept of requester 1's burst
        exp_own.push_back(1);
        push_wr(16'd400, 4'd4, 1'b0); push_wr(16'd401, 4'd5, 1'b0);
        send_beat(1, 16'd400, 4'd4, 1'b0);
        send_beat(1, 16'd401, 4'd5, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_we", {31'd0, fb_we}, 32'd0);
        check("rst_mid_grant", {30'd0, grant}, 32'd0);
        check("rst_mid_ready", {30'd0, req_ready}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_own.push_back(0); exp_own.push_back(1);
        push_wr(16'd500, 4'd6, 1'b0); push_wr(16'd600, 4'd7, 1'b0);
        fork
            begin burst(0, 1, 16'd500, 4'd6); drop(0); end
            begin burst(1, 1, 16'd600, 4'd7); drop(1); end
        join
        repeat (3) @(negedge clk);

`ifdef FB_WRITE_ARB_CLEAR_EN
        // Clear takes priority over a waiting requester
        for (int i = 0; i < NPIX; i++) push_wr(16'(i), 4'd5, (i == NPIX - 1));
        push_wr(16'd700, 4'd8, 1'b0);
        exp_own.push_back(0);
        fork
            begin
                @(negedge clk);
                clear_start = 1'b1;
                clear_cidx  = 4'd5;
                @(negedge clk);
                clear_start = 1'b0;
            end
            begin burst(0, 1, 16'd700, 4'd8); drop(0); end
        join
        repeat (3) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 32'd0);
        check("own_queue_empty", exp_own.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
